// File: rtl/l2_write_buffer.sv
// Victim write buffer between the L2 physical-memory port and memory.
// Writebacks are acknowledged from a small FIFO and drained to memory in idle cycles.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | accept upstream request, or start a drain when the buffer is non-empty
//   S_READ_MEM | read miss: memory read in flight
//   S_DRAIN    | head entry being written to memory; never aborted
//   S_RESP     | one-cycle completion pulse to L2
module l2_write_buffer #(
   parameter int BLOCK_W = 256,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  mem_address,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [BLOCK_W-1:0] mem_wdata,
   output logic [BLOCK_W-1:0] mem_rdata,
   output logic               mem_resp,
   output logic [ADDR_W-1:0]  pmem_address,
   output logic               pmem_read,
   output logic               pmem_write,
   output logic [BLOCK_W-1:0] pmem_wdata,
   input  logic [BLOCK_W-1:0] pmem_rdata,
   input  logic               pmem_resp
);
   localparam int OFS   = $clog2(BLOCK_W / 8);
   localparam int TAG_W = ADDR_W - OFS;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_READ_MEM, S_DRAIN, S_RESP} state_t;
   state_t state, state_nxt;

   logic [DEPTH-1:0]   ent_valid;
   logic [TAG_W-1:0]   ent_tag  [DEPTH];
   logic [BLOCK_W-1:0] ent_data [DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;
   logic [BLOCK_W-1:0] rdata_q;

   logic [TAG_W-1:0]   req_tag;
   logic               hit;
   logic [PTR_W-1:0]   hit_idx;
   logic               full;
   logic               do_rd_hit, do_rd_mem, do_coalesce, do_enq, do_pop;
   logic               unused_ofs;

   assign req_tag    = mem_address[ADDR_W-1:OFS];
   assign full       = (count == CNT_FULL);
   assign unused_ofs = ^mem_address[OFS-1:0];
   assign mem_rdata  = rdata_q;

   // Coalescing guarantees at most one valid entry per block, so the match is one-hot.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && (ent_tag[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      do_rd_hit    = 1'b0;
      do_rd_mem    = 1'b0;
      do_coalesce  = 1'b0;
      do_enq       = 1'b0;
      do_pop       = 1'b0;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state)
         S_IDLE: begin
            if (mem_read) begin
               if (hit) begin
                  do_rd_hit = 1'b1;
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_READ_MEM;
               end
            end else if (mem_write) begin
               if (hit) begin
                  do_coalesce = 1'b1;
                  state_nxt   = S_RESP;
               end else if (!full) begin
                  do_enq    = 1'b1;
                  state_nxt = S_RESP;
               end else begin
                  // write stays pending upstream until a slot frees
                  state_nxt = S_DRAIN;
               end
            end else if (count != '0) begin
               state_nxt = S_DRAIN;
            end
         end
         S_READ_MEM: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, {OFS{1'b0}}};
            if (pmem_resp) begin
               do_rd_mem = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_DRAIN: begin
            pmem_write   = 1'b1;
            pmem_address = {ent_tag[head], {OFS{1'b0}}};
            pmem_wdata   = ent_data[head];
            if (pmem_resp) begin
               do_pop    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_RESP: begin
            mem_resp  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Enqueue happens only in IDLE and pop only in DRAIN, so count never sees both at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         rdata_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i]  <= '0;
            ent_data[i] <= '0;
         end
      end else begin
         if (do_rd_hit)   rdata_q <= ent_data[hit_idx];
         if (do_rd_mem)   rdata_q <= pmem_rdata;
         if (do_coalesce) ent_data[hit_idx] <= mem_wdata;
         if (do_enq) begin
            ent_valid[tail] <= 1'b1;
            ent_tag[tail]   <= req_tag;
            ent_data[tail]  <= mem_wdata;
            tail            <= tail + 1'b1;
            count           <= count + 1'b1;
         end
         if (do_pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + 1'b1;
            count           <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench for l2_write_buffer: expected L2 responses and memory writes
// are queued as stimulus is driven and checked as the DUT produces them.
module tb_l2_write_buffer;
   localparam int BW = 256;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] mem_address;
   logic          mem_read, mem_write;
   logic [BW-1:0] mem_wdata, mem_rdata;
   logic          mem_resp;
   logic [AW-1:0] pmem_address;
   logic          pmem_read, pmem_write;
   logic [BW-1:0] pmem_wdata, pmem_rdata;
   logic          pmem_resp;

   l2_write_buffer #(.BLOCK_W(BW), .ADDR_W(AW), .DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct { logic is_rd; logic [BW-1:0] data; } rsp_t;
   typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; } wr_t;
   rsp_t rsp_q[$];
   wr_t  wr_q[$];
   rsp_t mon_rsp;
   wr_t  mon_wr;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, resp_delay = 1, wait_cnt = 0, last_presp_cyc = 0;
   int n_pwr = 0, n_prd_cyc = 0, n_pwr_cyc = 0;

   task automatic chk_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rd_pat(input logic [AW-1:0] a);
      logic [AW-1:0] x;
      x = a ^ 16'h5A3C;
      return {16{x}};
   endfunction

   function automatic logic [BW-1:0] mk_data(input int s);
      logic [31:0] w;
      w = 32'(s) * 32'h9E37_79B1 + 32'h0000_1234;
      return {8{w}};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: answers a held pmem request resp_delay cycles after it first appears
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         pmem_resp = 1'b0;
         if (!rst_n || !(pmem_read || pmem_write)) begin
            wait_cnt = 0;
         end else if (wait_cnt >= resp_delay) begin
            pmem_resp  = 1'b1;
            pmem_rdata = pmem_read ? rd_pat(pmem_address) : '0;
            wait_cnt   = 0;
         end else begin
            wait_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_resp) begin
            if (rsp_q.size() == 0) chk_eq("unexpected_resp", 1, 0);
            else begin
               mon_rsp = rsp_q.pop_front();
               if (mon_rsp.is_rd) chk_eq("mem_rdata", mem_rdata, mon_rsp.data);
            end
         end
         if (pmem_read)  n_prd_cyc++;
         if (pmem_write) n_pwr_cyc++;
         if (pmem_read || pmem_write) chk_eq("pmem_align", pmem_address[4:0], 0);
         if (pmem_read && pmem_write) chk_eq("rd_wr_excl", 1, 0);
         if (pmem_resp) last_presp_cyc = cyc;
         if (pmem_write && pmem_resp) begin
            n_pwr++;
            if (wr_q.size() == 0) chk_eq("unexpected_pwrite", 1, 0);
            else begin
               mon_wr = wr_q.pop_front();
               chk_eq("pwr_addr", pmem_address, mon_wr.addr);
               chk_eq("pwr_data", pmem_wdata, mon_wr.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // For reads, d is the data expected back; for writes, it is the data written.
   task automatic req(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                      input int exp_lat, input string tag);
      int   n;
      rsp_t e;
      n       = 0;
      e.is_rd = !wr;
      e.data  = wr ? '0 : d;
      rsp_q.push_back(e);
      mem_address = a;
      mem_read    = !wr;
      mem_write   = wr;
      mem_wdata   = wr ? d : '0;
      do begin
         tick();
         n++;
      end while (!mem_resp && n < 200);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk_eq({tag, "_lat"}, n, exp_lat);
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      wr_q.push_back(w);
   endtask

   task automatic wait_empty(input string tag);
      int  n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 400) begin
         tick();
         n++;
         done = (dut.count == 0) && !pmem_write && !pmem_read && !mem_resp;
      end
      chk_eq(tag, done, 1);
   endtask

   initial begin
      int w0, p0, n;
      mem_address = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wdata   = '0;

      repeat (3) tick();
      chk_eq("rst_ctl", {mem_resp, pmem_read, pmem_write, pmem_address}, 0);
      chk_eq("rst_data", {mem_rdata, pmem_wdata} != '0, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // single write, acknowledged at once, drained in the next idle slot
      resp_delay = 3;
      push_wr(16'h0040, mk_data(1));
      req(1'b1, 16'h0040, mk_data(1), 1, "t1_wr");
      chk_eq("t1_no_pmem", {pmem_read, pmem_write}, 0);
      tick();
      chk_eq("t1_idle_gap", pmem_write, 0);
      tick();
      chk_eq("t1_drain", pmem_write, 1);
      chk_eq("t1_drain_addr", pmem_address, 16'h0040);
      repeat (3) tick();
      chk_eq("t1_cnt_pre", dut.count, 1);
      tick();
      chk_eq("t1_cnt_post", dut.count, 0);
      chk_eq("t1_pwr", n_pwr, 1);

      // read hit served from the buffer
      resp_delay = 2;
      push_wr(16'h0100, mk_data(2));
      p0 = n_prd_cyc;
      req(1'b1, 16'h0100, mk_data(2), 1, "t2_wr");
      req(1'b0, 16'h0110, mk_data(2), 2, "t2_rd");
      chk_eq("t2_no_pread", n_prd_cyc - p0, 0);
      wait_empty("t2_drain");

      // coalescing into one entry
      push_wr(16'h0200, mk_data(4));
      w0 = n_pwr;
      req(1'b1, 16'h0200, mk_data(3), 1, "t3_wr1");
      chk_eq("t3_cnt1", dut.count, 1);
      req(1'b1, 16'h0208, mk_data(4), 2, "t3_wr2");
      chk_eq("t3_cnt2", dut.count, 1);
      wait_empty("t3_drain");
      chk_eq("t3_one_pwr", n_pwr - w0, 1);

      // fill the buffer, then a fifth write forces a drain of the oldest
      resp_delay = 10;
      for (int i = 0; i < 5; i++) push_wr(16'h1000 + 16'(i * 32), mk_data(10 + i));
      req(1'b1, 16'h1000, mk_data(10), 1, "t4_wr0");
      for (int i = 1; i < 4; i++) req(1'b1, 16'h1000 + 16'(i * 32), mk_data(10 + i), 2, "t4_wr");
      chk_eq("t4_full", dut.count, 4);
      req(1'b1, 16'h1080, mk_data(14), 14, "t4_wr_full");
      chk_eq("t4_gap", cyc - last_presp_cyc, 2);
      chk_eq("t4_cnt", dut.count, 4);
      resp_delay = 1;
      wait_empty("t4_drain");

      // read miss takes priority over draining a buffered block
      resp_delay = 2;
      push_wr(16'h0300, mk_data(20));
      w0 = n_pwr;
      req(1'b1, 16'h0300, mk_data(20), 1, "t5_wr");
      req(1'b0, 16'h0417, rd_pat(16'h0400), 5, "t5_rd");
      chk_eq("t5_rd_first", n_pwr - w0, 0);
      chk_eq("t5_gap", cyc - last_presp_cyc, 1);
      wait_empty("t5_drain");
      chk_eq("t5_pwr", n_pwr - w0, 1);

      // reset in the middle of a drain abandons it
      resp_delay = 1000;
      req(1'b1, 16'h0500, mk_data(30), 1, "t6_wr");
      n = 0;
      while (!pmem_write && n < 20) begin
         tick();
         n++;
      end
      chk_eq("t6_drain_seen", pmem_write, 1);
      rst_n = 1'b0;
      tick();
      chk_eq("t6_rst_ctl", {mem_resp, pmem_read, pmem_write, pmem_address}, 0);
      chk_eq("t6_rst_data", {mem_rdata, pmem_wdata} != '0, 0);
      chk_eq("t6_rst_cnt", dut.count, 0);
      rst_n      = 1'b1;
      resp_delay = 1;
      w0         = n_pwr_cyc;
      repeat (10) tick();
      chk_eq("t6_no_drain", n_pwr_cyc - w0, 0);

      // recovers normally: read miss from IDLE
      req(1'b0, 16'h0600, rd_pat(16'h0600), 3, "t7_rd");
      repeat (3) tick();

      chk_eq("rsp_q_left", rsp_q.size(), 0);
      chk_eq("wr_q_left", wr_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
